// File: rtl/step_counter_pkg.sv
// step_counter_pkg
//   Shared definitions for the microstep counter.
//   MAX_WIDTH  : largest supported counter width
//   MODE_WRAP  : SAT value selecting modulo-2**WIDTH counting
//   MODE_SAT   : SAT value selecting saturation at all-ones / zero
//   step_next(): next counter value for a single +1/-1 step, plus a flag
//                telling whether the step hit the boundary.
package step_counter_pkg;

   localparam int MAX_WIDTH = 6;
   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;

   localparam logic [MAX_WIDTH-1:0] ONE = MAX_WIDTH'(1);

   // Returns {boundary_hit, next_value}. The value is computed at MAX_WIDTH
   // bits but never leaves the 0..2**width-1 range, so the caller may keep
   // only its low 'width' bits.
   function automatic logic [MAX_WIDTH:0] step_next(
      input logic [MAX_WIDTH-1:0] cur,
      input logic                 up,
      input logic                 sat,
      input int                   width
   );
      logic [MAX_WIDTH-1:0] all_ones;
      logic [MAX_WIDTH-1:0] nxt;
      logic                 hit;
      all_ones = MAX_WIDTH'((1 << width) - 1);
      hit      = 1'b0;
      nxt      = cur;
      if (up) begin
         hit = (cur == all_ones);
         if (hit) nxt = sat ? all_ones : '0;
         else     nxt = cur + ONE;
      end else begin
         hit = (cur == '0);
         if (hit) nxt = sat ? '0 : all_ones;
         else     nxt = cur - ONE;
      end
      return {hit, nxt};
   endfunction

endpackage

// File: rtl/step_counter_decode.sv
// step_decode
//   Pure combinational decode of the counter value.
//   cnt  in   WIDTH        counter value (normal MSB-left numbering)
//   step out  2**WIDTH     one-hot, step[k] = (cnt == k), index 0 is leftmost
//   nz   out  1            cnt != 0
module step_decode #(
   parameter int WIDTH = 2
) (
   input  logic [WIDTH-1:0]        cnt,
   output logic [0:(1<<WIDTH)-1]   step,
   output logic                    nz
);

   genvar gi;
   generate
      for (gi = 0; gi < (1 << WIDTH); gi++) begin : g_dec
         assign step[gi] = (cnt == WIDTH'(gi));
      end
   endgenerate

   assign nz = |cnt;

endmodule

// File: rtl/step_counter.sv
// step_counter
//   Parametrised microstep counter: step up/down, preload, clear, wrap or
//   saturate, registered boundary pulse and one-hot step decode.
//   Optional feature macro: STEP_COUNTER_OVF_EN (sticky overflow flag).
// Parameters
//   WIDTH  counter width 1..MAX_WIDTH
//   SAT    MODE_WRAP (0) or MODE_SAT (1)
// Ports
//   clk_sys  in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   inc/dec  in   step +1 / -1 (both together = hold)
//   load/val in   preload cnt with val (val bit 0 = MSB)
//   clr      in   preload zero
//   cnt      out  current step (bit 0 = MSB)
//   nz       out  cnt != 0
//   step     out  one-hot decode, step[k] = (cnt == k)
//   wrap     out  1-cycle pulse after a boundary step
//   ovf      out  sticky boundary flag (0 when STEP_COUNTER_OVF_EN undefined)
module step_counter
   import step_counter_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int SAT   = MODE_WRAP
) (
   input  logic                   clk_sys,
   input  logic                   rst,
   input  logic                   inc,
   input  logic                   dec,
   input  logic                   load,
   input  logic [0:WIDTH-1]       val,
   input  logic                   clr,
   output logic [0:WIDTH-1]       cnt,
   output logic                   nz,
   output logic [0:(1<<WIDTH)-1]  step,
   output logic                   wrap,
   output logic                   ovf
);

   logic [WIDTH-1:0]   cnt_reg, cnt_next;
   logic               wrap_reg, wrap_next;
   logic               step_en;
   logic               boundary;
   logic [MAX_WIDTH:0] step_res;

   // Exactly one of inc/dec is a real step; both together cancel out.
   assign step_en  = inc ^ dec;
   assign step_res = step_next(MAX_WIDTH'(cnt_reg), inc, (SAT == MODE_SAT), WIDTH);
   assign boundary = step_res[MAX_WIDTH];

   // Bits above WIDTH are always zero; tie them off explicitly.
   generate
      if (WIDTH < MAX_WIDTH) begin : g_unused
         logic unused_hi_bits;
         assign unused_hi_bits = &{1'b0, step_res[MAX_WIDTH-1:WIDTH]};
      end
   endgenerate

   always_comb begin
      cnt_next  = cnt_reg;
      wrap_next = 1'b0;
      if (step_en) begin
         cnt_next  = step_res[WIDTH-1:0];
         wrap_next = boundary;
      end else if (inc & dec) begin
         cnt_next  = cnt_reg;       // net hold, load/clr ignored
      end else if (load) begin
         cnt_next  = val;
      end else if (clr) begin
         cnt_next  = '0;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         cnt_reg  <= '0;
         wrap_reg <= 1'b0;
      end else begin
         cnt_reg  <= cnt_next;
         wrap_reg <= wrap_next;
      end
   end

`ifdef STEP_COUNTER_OVF_EN
   logic ovf_reg, ovf_next;

   // Set on any boundary step. clr clears it only on edges with neither inc
   // nor dec asserted, independent of load (load itself never clears it).
   always_comb begin
      ovf_next = ovf_reg;
      if (wrap_next)
         ovf_next = 1'b1;
      else if (clr & ~inc & ~dec)
         ovf_next = 1'b0;
   end

   always_ff @(posedge clk_sys) begin
      if (rst) ovf_reg <= 1'b0;
      else     ovf_reg <= ovf_next;
   end

   assign ovf = ovf_reg;
`else
   assign ovf = 1'b0;
`endif

   assign cnt  = cnt_reg;
   assign wrap = wrap_reg;

   step_decode #(.WIDTH(WIDTH)) u_decode (
      .cnt  (cnt_reg),
      .step (step),
      .nz   (nz)
   );

endmodule

// File: tb/tb_step_counter.sv
module tb_step_counter;

   logic clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   logic       rst = 1'b1, inc = 1'b0, dec = 1'b0, load = 1'b0, clr = 1'b0;
   logic [0:1] val2 = '0;
   logic [0:3] val4 = '0;

   logic [0:1]  cnt_a, cnt_b;
   logic [0:3]  cnt_c;
   logic        nz_a, nz_b, nz_c, wrap_a, wrap_b, wrap_c, ovf_a, ovf_b, ovf_c;
   logic [0:3]  step_a, step_b;
   logic [0:15] step_c;

   // A: WIDTH=2 wrap, B: WIDTH=2 saturate, C: WIDTH=4 wrap
   step_counter #(.WIDTH(2), .SAT(0)) dut_a (
      .clk_sys(clk_sys), .rst(rst), .inc(inc), .dec(dec), .load(load), .val(val2),
      .clr(clr), .cnt(cnt_a), .nz(nz_a), .step(step_a), .wrap(wrap_a), .ovf(ovf_a));
   step_counter #(.WIDTH(2), .SAT(1)) dut_b (
      .clk_sys(clk_sys), .rst(rst), .inc(inc), .dec(dec), .load(load), .val(val2),
      .clr(clr), .cnt(cnt_b), .nz(nz_b), .step(step_b), .wrap(wrap_b), .ovf(ovf_b));
   step_counter #(.WIDTH(4), .SAT(0)) dut_c (
      .clk_sys(clk_sys), .rst(rst), .inc(inc), .dec(dec), .load(load), .val(val4),
      .clr(clr), .cnt(cnt_c), .nz(nz_c), .step(step_c), .wrap(wrap_c), .ovf(ovf_c));

   typedef struct {
      int cnt;
      bit wrap;
      bit ovf;
   } mstate_t;

   typedef struct {
      mstate_t a;
      mstate_t b;
      mstate_t c;
      string   tag;
   } exp_t;

   exp_t    sb_q[$];
   mstate_t ma = '{0, 1'b0, 1'b0};
   mstate_t mb = '{0, 1'b0, 1'b0};
   mstate_t mc = '{0, 1'b0, 1'b0};
   int      total = 0;
   int      bad   = 0;

   // Reference model: counter as an integer in 0..2**w-1.
   function automatic mstate_t model(mstate_t s, int w, bit sat, bit r, bit i, bit d,
                                     bit l, bit c, int v);
      int      top;
      mstate_t n;
      top    = (1 << w) - 1;
      n      = s;
      n.wrap = 1'b0;
      if (r) begin
         n.cnt = 0;
         n.ovf = 1'b0;
         return n;
      end
      if (i && !d) begin
         if (s.cnt == top) begin
            n.wrap = 1'b1;
            n.cnt  = sat ? top : 0;
         end else n.cnt = s.cnt + 1;
      end else if (d && !i) begin
         if (s.cnt == 0) begin
            n.wrap = 1'b1;
            n.cnt  = sat ? 0 : top;
         end else n.cnt = s.cnt - 1;
      end else if (i && d) begin
         n.cnt = s.cnt;
      end else if (l) begin
         n.cnt = v % (top + 1);
      end else if (c) begin
         n.cnt = 0;
      end
`ifdef STEP_COUNTER_OVF_EN
      if (n.wrap) n.ovf = 1'b1;
      else if (c && !i && !d) n.ovf = 1'b0;
`else
      n.ovf = 1'b0;
`endif
      return n;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic check_inst(input string inst, input string tag, input mstate_t s,
                             input int w, input int a_cnt, input int a_nz,
                             input int a_step, input int a_wrap, input int a_ovf);
      int ones;
      ones = (1 << (1 << w)) - 1;
      chk($sformatf("%s.%s.cnt", inst, tag), a_cnt, s.cnt);
      chk($sformatf("%s.%s.nz", inst, tag), a_nz, (s.cnt != 0) ? 1 : 0);
      // step[0] is the leftmost bit of the decode vector
      chk($sformatf("%s.%s.step", inst, tag), a_step & ones, 1 << (((1 << w) - 1) - s.cnt));
      chk($sformatf("%s.%s.wrap", inst, tag), a_wrap, int'(s.wrap));
      chk($sformatf("%s.%s.ovf", inst, tag), a_ovf, int'(s.ovf));
   endtask

   // Monitor: one expected entry per clock edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk_sys);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_inst("A", e.tag, e.a, 2, int'(cnt_a), int'(nz_a), int'(step_a),
                       int'(wrap_a), int'(ovf_a));
            check_inst("B", e.tag, e.b, 2, int'(cnt_b), int'(nz_b), int'(step_b),
                       int'(wrap_b), int'(ovf_b));
            check_inst("C", e.tag, e.c, 4, int'(cnt_c), int'(nz_c), int'(step_c),
                       int'(wrap_c), int'(ovf_c));
            $display("txn %-8s A cnt=%0d wrap=%0d ovf=%0d | B cnt=%0d wrap=%0d | C cnt=%0d wrap=%0d",
                     e.tag, cnt_a, wrap_a, ovf_a, cnt_b, wrap_b, cnt_c, wrap_c);
         end
      end
   end

   task automatic drive(input bit r, input bit i, input bit d, input bit l, input bit c,
                        input int v, input string tag);
      exp_t e;
      @(negedge clk_sys);
      rst  = r;
      inc  = i;
      dec  = d;
      load = l;
      clr  = c;
      val2 = 2'(v);
      val4 = 4'(v);
      ma = model(ma, 2, 1'b0, r, i, d, l, c, v);
      mb = model(mb, 2, 1'b1, r, i, d, l, c, v);
      mc = model(mc, 4, 1'b0, r, i, d, l, c, v);
      e.a   = ma;
      e.b   = mb;
      e.c   = mc;
      e.tag = tag;
      sb_q.push_back(e);
   endtask

   initial begin
      // reset beats inc/load
      drive(1, 1, 0, 1, 0, 3, "reset");
      // four increments from zero
      repeat (4) drive(0, 1, 0, 0, 0, 0, "inc4");
      // saturate / wrap at top and bottom
      drive(0, 0, 0, 1, 0, 3, "ld3");
      drive(0, 1, 0, 0, 0, 0, "inc_top");
      drive(0, 0, 0, 0, 1, 0, "clr");
      drive(0, 0, 1, 0, 0, 0, "dec_bot");
      // priority
      drive(0, 0, 0, 1, 0, 1, "ld1");
      drive(0, 1, 0, 1, 0, 2, "inc_ld");
      drive(0, 0, 0, 1, 1, 3, "ld_clr");
      drive(0, 1, 1, 0, 1, 0, "incdec");
      // sticky flag behaviour
      drive(0, 0, 0, 0, 1, 0, "clr");
      drive(0, 0, 1, 0, 0, 0, "dec0");
      drive(0, 0, 0, 1, 0, 1, "ld_ovf");
      drive(0, 0, 0, 0, 1, 0, "clr_ovf");
      // wider counter wrapping from 4'hF
      drive(0, 0, 0, 1, 0, 15, "ldF");
      drive(0, 1, 0, 0, 0, 0, "incF");
      drive(0, 0, 0, 0, 0, 0, "hold");
      // random traffic
      for (int k = 0; k < 300; k++) begin
         drive(($urandom_range(0, 40) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
               int'($urandom_range(0, 15)), "rand");
      end
      drive(0, 0, 0, 0, 0, 0, "idle");
      repeat (2) @(posedge clk_sys);
      #2;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expected 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
